// File: rtl/axis_write_data_pkg.sv
// Shared types and helpers for the streaming DMA write-data path.
package axis_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_write_data_if.sv
// Bundles the cfg, stream and AXI W channel signals of the write-data path.
interface axis_write_data_if #(
    parameter int CFG_DWIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH = 256
);
    logic [CFG_DWIDTH-1:0]       cfg_length;
    logic                        cfg_valid;
    logic                        cfg_ready;
    logic [DATA_WIDTH-1:0]       data;
    logic                        valid;
    logic                        ready;
    logic [AXI_DATA_WIDTH-1:0]   axi_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb;
    logic                        axi_wlast;
    logic                        axi_wvalid;
    logic                        axi_wready;

    modport slave (
        input  cfg_length, cfg_valid, data, valid, axi_wready,
        output cfg_ready, ready, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid
    );

    modport master (
        output cfg_length, cfg_valid, data, valid, axi_wready,
        input  cfg_ready, ready, axi_wdata, axi_wstrb, axi_wlast, axi_wvalid
    );
endinterface

// File: rtl/axis_write_data_fifo.sv
// First-word-fall-through synchronous FIFO; read data reads as zero while empty.
module fifo_simple #(
    parameter int WIDTH  = 289,
    parameter int AWIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << AWIDTH;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              do_wr, do_rd;

    assign full    = (count_q == (AWIDTH+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_rd   = rd_en && !empty;
    // A write into a full FIFO is fine when the same cycle frees a slot.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AWIDTH'(1);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (AWIDTH+1)'(1);
            2'b01:   count_d = count_q - (AWIDTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/axis_write_data.sv
// Packs narrow stream words into AXI write beats, buffers them and drives the W channel.
module axis_write_data
    import axis_pkg::*;
#(
    parameter int BUF_AWIDTH     = 4,
    parameter int CFG_DWIDTH     = 32,
    parameter int WIDTH_RATIO    = 8,
    parameter int AXI_DATA_WIDTH = 256,
    parameter int DATA_WIDTH     = 32,
    parameter int BURST_LEN      = 16
) (
    input  logic             clk,
    input  logic             rst,
    axis_write_data_if.slave bus
);
    localparam int IDX_W  = (clog2(WIDTH_RATIO) > 0) ? clog2(WIDTH_RATIO) : 1;
    localparam int BCNT_W = (clog2(BURST_LEN) > 0) ? clog2(BURST_LEN) : 1;
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int BPW    = DATA_WIDTH / 8;
    localparam int FIFO_W = AXI_DATA_WIDTH + STRB_W + 1;
    localparam logic [CFG_DWIDTH-1:0] RATIO_C = CFG_DWIDTH'(WIDTH_RATIO);

    generate
        if (AXI_DATA_WIDTH != WIDTH_RATIO * DATA_WIDTH) begin : g_width_check
            $error("AXI_DATA_WIDTH must equal WIDTH_RATIO*DATA_WIDTH");
        end
    endgenerate

    state_t                                 state_q, state_d;
    logic [CFG_DWIDTH-1:0]                  words_left_q, words_left_d;
    logic [CFG_DWIDTH-1:0]                  beats_left_q, beats_left_d;
    logic [IDX_W-1:0]                       word_idx_q, word_idx_d;
    logic [BCNT_W-1:0]                      burst_cnt_q, burst_cnt_d;
    logic [WIDTH_RATIO-1:0][DATA_WIDTH-1:0] pack_q, pack_d, beat_lanes;
    logic [STRB_W-1:0]                      beat_strb;
    logic                                   beat_last, burst_wrap, last_word;
    logic                                   push, pop, accept, ready_c, cfg_ready_c;
    logic                                   fifo_full, fifo_empty;
    logic [FIFO_W-1:0]                      fifo_rd;

    assign pop        = !fifo_empty && bus.axi_wready;
    assign last_word  = (words_left_q == CFG_DWIDTH'(1));
    assign burst_wrap = (burst_cnt_q == BCNT_W'(BURST_LEN - 1));
    assign beat_last  = last_word || burst_wrap;
    assign accept     = bus.valid && ready_c;
    assign push       = accept && ((word_idx_q == IDX_W'(WIDTH_RATIO - 1)) || last_word);

    // The word being accepted goes straight into the outgoing beat so a
    // completed beat reaches the FIFO in the same cycle.
    always_comb begin
        beat_lanes             = pack_q;
        beat_lanes[word_idx_q] = bus.data;
        beat_strb              = '0;
        for (int i = 0; i < WIDTH_RATIO; i++) begin
            if (IDX_W'(i) <= word_idx_q) beat_strb[i*BPW +: BPW] = '1;
        end
    end

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        beats_left_d = beats_left_q;
        word_idx_d   = word_idx_q;
        burst_cnt_d  = burst_cnt_q;
        pack_d       = pack_q;
        cfg_ready_c  = (state_q == IDLE) && !rst;
        ready_c      = (state_q == ACTIVE) && (words_left_q != '0) && (!fifo_full || pop);
        if (pop) beats_left_d = beats_left_q - CFG_DWIDTH'(1);
        case (state_q)
            IDLE: begin
                if (bus.cfg_valid && cfg_ready_c) begin
                    words_left_d = bus.cfg_length;
                    beats_left_d = bus.cfg_length / RATIO_C
                                 + CFG_DWIDTH'((bus.cfg_length % RATIO_C) != '0);
                    word_idx_d   = '0;
                    burst_cnt_d  = '0;
                    pack_d       = '0;
                    state_d      = (bus.cfg_length == '0) ? DONE : ACTIVE;
                end
            end
            ACTIVE: begin
                if (accept) begin
                    words_left_d = words_left_q - CFG_DWIDTH'(1);
                    if (push) begin
                        pack_d      = '0;
                        word_idx_d  = '0;
                        burst_cnt_d = burst_wrap ? '0 : burst_cnt_q + BCNT_W'(1);
                    end else begin
                        pack_d[word_idx_q] = bus.data;
                        word_idx_d         = word_idx_q + IDX_W'(1);
                    end
                    if (last_word) state_d = DRAIN;
                end
            end
            // Look at the post-pop count so the final handshake releases us at once.
            DRAIN:   if (beats_left_d == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            words_left_q <= '0;
            beats_left_q <= '0;
            word_idx_q   <= '0;
            burst_cnt_q  <= '0;
            pack_q       <= '0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            beats_left_q <= beats_left_d;
            word_idx_q   <= word_idx_d;
            burst_cnt_q  <= burst_cnt_d;
            pack_q       <= pack_d;
        end
    end

    fifo_simple #(
        .WIDTH  (FIFO_W),
        .AWIDTH (BUF_AWIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({beat_last, beat_strb, beat_lanes}),
        .rd_en   (bus.axi_wready),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.cfg_ready  = cfg_ready_c;
    assign bus.ready      = ready_c;
    assign bus.axi_wvalid = !fifo_empty;
    assign bus.axi_wdata  = fifo_rd[AXI_DATA_WIDTH-1:0];
    assign bus.axi_wstrb  = fifo_rd[AXI_DATA_WIDTH +: STRB_W];
    assign bus.axi_wlast  = fifo_rd[FIFO_W-1];
endmodule

// File: tb/tb_axis_write_data.sv
// Directed bench for axis_write_data: reset abort, packing, bursts, backpressure, bubbles.
module tb_axis_write_data;
    localparam int DW = 32;
    localparam int R  = 8;
    localparam int AW = 256;
    localparam int SW = AW / 8;
    localparam int BL = 16;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axis_write_data_if #(.CFG_DWIDTH(CW), .DATA_WIDTH(DW), .AXI_DATA_WIDTH(AW)) bus();

    axis_write_data #(
        .BUF_AWIDTH(4), .CFG_DWIDTH(CW), .WIDTH_RATIO(R),
        .AXI_DATA_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // W channel monitor: records handshaken beats and checks hold-while-stalled.
    logic [AW-1:0] q_data [$];
    logic [SW-1:0] q_strb [$];
    logic          q_last [$];
    int            q_cyc  [$];
    logic          stall_q = 1'b0;
    logic [AW+SW:0] held = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (stall_q && bus.axi_wvalid)
                chk("w_stable", {bus.axi_wlast, bus.axi_wstrb, bus.axi_wdata}, held);
            if (bus.axi_wvalid && bus.axi_wready) begin
                q_data.push_back(bus.axi_wdata);
                q_strb.push_back(bus.axi_wstrb);
                q_last.push_back(bus.axi_wlast);
                q_cyc.push_back(cyc);
            end
        end
        stall_q = !rst && bus.axi_wvalid && !bus.axi_wready;
        held    = {bus.axi_wlast, bus.axi_wstrb, bus.axi_wdata};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete(); q_strb.delete(); q_last.delete(); q_cyc.delete();
    endtask

    task automatic send_cfg(input logic [CW-1:0] len, output int hs_cyc);
        int n;
        n = 0;
        bus.cfg_length = len;
        bus.cfg_valid  = 1'b1;
        @(negedge clk);
        while (!bus.cfg_ready && n < 200) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk("cfg_hs", bus.cfg_ready, 1);
        hs_cyc = cyc;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic stream(input int first, input int n, input bit bubbles,
                          input int budget, output int got);
        int  t;
        bit  hs;
        t   = 0;
        got = 0;
        while (got < n && t < budget) begin
            bus.valid = !(bubbles && (t % 2 == 1));
            bus.data  = DW'(first + got);
            @(negedge clk);
            hs = bus.valid && bus.ready;
            tick();
            if (hs) got++;
            t++;
        end
        bus.valid = 1'b0;
    endtask

    task automatic wait_idle(output int c);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.cfg_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", bus.cfg_ready, 1);
        c = cyc;
    endtask

    // Words are numbered 1..L in stream order; beat b lane j carries word b*R+j+1.
    task automatic check_xfer(input int L);
        int nb;
        logic [AW-1:0] ed;
        logic [SW-1:0] es;
        nb = (L + R - 1) / R;
        chk("n_beats", q_data.size(), nb);
        for (int b = 0; b < nb && b < q_data.size(); b++) begin
            ed = '0;
            es = '0;
            for (int j = 0; j < R; j++) begin
                if (b * R + j < L) begin
                    ed[j*DW +: DW] = DW'(b * R + j + 1);
                    es[j*4 +: 4]   = 4'hF;
                end
            end
            chk($sformatf("beat%0d_data", b), q_data[b], ed);
            chk($sformatf("beat%0d_strb", b), q_strb[b], es);
            chk($sformatf("beat%0d_last", b), q_last[b], ((b + 1) % BL == 0) || (b == nb - 1));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int hs, c, got;
        logic [AW-1:0] exp_b;

        bus.cfg_length = '0;
        bus.cfg_valid  = 1'b0;
        bus.data       = '0;
        bus.valid      = 1'b0;
        bus.axi_wready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("por_cfg_ready", bus.cfg_ready, 1);
        chk("por_wvalid", bus.axi_wvalid, 0);
        tick();

        // Reset in the middle of a transfer: one beat buffered plus a partial packer.
        send_cfg(20, hs);
        stream(1, 12, 1'b0, 40, got);
        chk("pre_rst_words", got, 12);
        @(negedge clk);
        chk("pre_rst_wvalid", bus.axi_wvalid, 1);
        tick();
        rst = 1'b1;
        tick();
        repeat (5) begin
            @(negedge clk);
            chk("rst_cfg_ready", bus.cfg_ready, 0);
            chk("rst_ready", bus.ready, 0);
            chk("rst_wvalid", bus.axi_wvalid, 0);
            chk("rst_wlast", bus.axi_wlast, 0);
            chk("rst_wdata", bus.axi_wdata, 0);
            chk("rst_wstrb", bus.axi_wstrb, 0);
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cfg_ready", bus.cfg_ready, 1);
        chk("post_rst_wvalid", bus.axi_wvalid, 0);
        tick();

        // Length 10 with an always-ready W channel.
        bus.axi_wready = 1'b1;
        clear_q();
        send_cfg(10, hs);
        stream(1, 10, 1'b0, 100, got);
        chk("len10_words", got, 10);
        wait_idle(c);
        check_xfer(10);
        if (q_data.size() == 2) begin
            chk("len10_b0_data", q_data[0],
                256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
            chk("len10_b0_strb", q_strb[0], 32'hFFFFFFFF);
            chk("len10_b1_data", q_data[1], 256'h0000000a_00000009);
            chk("len10_b1_strb", q_strb[1], 32'h000000FF);
            chk("len10_b1_last", q_last[1], 1);
            chk("len10_idle_gap", c - q_cyc[1], 2);
        end
        tick();

        // Length 0: straight through DONE, no data path activity.
        clear_q();
        send_cfg(0, hs);
        @(negedge clk);
        chk("len0_cfg_ready_done", bus.cfg_ready, 0);
        chk("len0_ready", bus.ready, 0);
        chk("len0_wvalid", bus.axi_wvalid, 0);
        tick();
        @(negedge clk);
        chk("len0_cfg_ready_back", bus.cfg_ready, 1);
        chk("len0_gap", cyc - hs, 2);
        chk("len0_beats", q_data.size(), 0);
        tick();

        // 20 full beats: wlast only on beats 16 and 20.
        clear_q();
        send_cfg(160, hs);
        stream(1, 160, 1'b0, 400, got);
        chk("len160_words", got, 160);
        wait_idle(c);
        check_xfer(160);
        tick();

        // Backpressure: FIFO fills at 16 beats, then drains in order.
        bus.axi_wready = 1'b0;
        clear_q();
        send_cfg(136, hs);
        stream(1, 136, 1'b0, 160, got);
        chk("bp_accepted", got, 128);
        @(negedge clk);
        exp_b = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
        chk("bp_wvalid", bus.axi_wvalid, 1);
        chk("bp_ready_full", bus.ready, 0);
        chk("bp_head_data", bus.axi_wdata, exp_b);
        tick();
        bus.axi_wready = 1'b1;
        @(negedge clk);
        chk("bp_ready_full_pop", bus.ready, 1);
        tick();
        stream(129, 8, 1'b0, 100, got);
        chk("bp_rest_words", got, 8);
        wait_idle(c);
        check_xfer(136);
        tick();

        // Bubbles on the stream side, length 12.
        clear_q();
        send_cfg(12, hs);
        stream(1, 12, 1'b1, 100, got);
        chk("bub_words", got, 12);
        wait_idle(c);
        check_xfer(12);
        if (q_data.size() == 2) begin
            chk("bub_b1_data", q_data[1], 256'h0000000c_0000000b_0000000a_00000009);
            chk("bub_b1_strb", q_strb[1], 32'h0000FFFF);
            chk("bub_b1_last", q_last[1], 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
